// File: rtl/fpu_pkg.sv
// Shared floating-point package for the fpu blocks (adder, float-to-int).
// Holds the rounding-mode encodings, IEEE 754 single-precision limits,
// the 32-bit integer limits and the operand-class enumeration, plus a
// small classification helper used by every unpack stage.
package fpu_pkg;

    // Rounding modes as carried on the mode inputs of the fpu blocks.
    typedef enum logic [1:0] {
        RM_RNE = 2'b00,   // round to nearest, ties to even
        RM_RZ  = 2'b01,   // round toward zero
        RM_RUP = 2'b10,   // round toward +infinity
        RM_RDN = 2'b11    // round toward -infinity
    } round_mode_t;

    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'd255;
    localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    // Biased exponent of 2^31: the first exponent whose magnitude no longer
    // fits a signed 32-bit integer (only -2^31 itself is representable).
    localparam logic [7:0]  EXP_INT_LIMIT = 8'(EXP_BIAS + 31);

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [7:0] exp_f, input logic [22:0] frac_f);
        fp_class_t cls;
        if (exp_f == EXP_MAX) begin
            cls = (frac_f != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (exp_f == 8'd0) begin
            cls = (frac_f != 23'd0) ? CLS_DENORM : CLS_ZERO;
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fpu_align_shift.sv
// Combinational alignment shifter for float-to-int conversion.
// The 24-bit significand (hidden bit included) is placed with its leading
// bit at integer weight 2^31 and shifted right by shamt.
//   sig     : {1, frac}
//   shamt   : right shift amount (31 - unbiased exponent); any value >= 64
//             pushes every significand bit into sticky
//   int_mag : integer part of the magnitude
//   guard   : first fraction bit (weight 1/2)
//   sticky  : OR of all fraction bits below guard
module fpu_align_shift
    import fpu_pkg::*;
(
    input  logic [23:0] sig,
    input  logic [7:0]  shamt,
    output logic [31:0] int_mag,
    output logic        guard,
    output logic        sticky
);

    logic [63:0] wide;
    logic [63:0] shifted;
    logic [63:0] lost_mask;
    logic        lost;

    always_comb begin
        wide      = {sig, 40'd0};
        // Shifts of 64 or more yield all zeros, which is exactly the
        // behaviour wanted for very small exponents.
        shifted   = wide >> shamt;
        lost_mask = ~({64{1'b1}} << shamt);
        lost      = |(wide & lost_mask);
    end

    assign int_mag = shifted[63:32];
    assign guard   = shifted[31];
    assign sticky  = (|shifted[30:0]) | lost;

endmodule

// File: rtl/fpu_f2i.sv
// IEEE 754 single-precision to signed 32-bit integer converter.
// Four register levels: input capture, S1 unpack/classify, S2 align,
// S3 round/negate/saturate into the output register. An operand accepted
// at edge k is visible on the outputs after edge k+3 when not stalled.
// The whole pipeline advances together: advance = !out_valid || out_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (opa_in, mode_in)
//   out_valid/out_ready result handshake (out, invalid, inexact, zero)
module fpu_f2i
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opa_in,
    input  logic [1:0]  mode_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        invalid,
    output logic        inexact,
    output logic        zero
);

    logic advance;

    // Capture stage
    logic        s0_valid_reg;
    logic [31:0] s0_opa_reg;
    round_mode_t s0_mode_reg;

    // S1: unpack and classify
    logic        s1_valid_reg;
    logic        s1_sign_reg,  s1_sign_next;
    logic [7:0]  s1_exp_reg,   s1_exp_next;
    logic [22:0] s1_frac_reg,  s1_frac_next;
    fp_class_t   s1_class_reg, s1_class_next;
    round_mode_t s1_mode_reg;

    // S2: align
    logic        s2_valid_reg;
    logic        s2_sign_reg;
    round_mode_t s2_mode_reg;
    logic        s2_nan_reg,    s2_nan_next;
    logic        s2_sat_reg,    s2_sat_next;
    logic [31:0] s2_int_reg,    s2_int_next;
    logic        s2_guard_reg,  s2_guard_next;
    logic        s2_sticky_reg, s2_sticky_next;

    // S3: output register
    logic        out_valid_reg;
    logic [31:0] out_reg,     out_next;
    logic        invalid_reg, invalid_next;
    logic        inexact_reg, inexact_next;
    logic        zero_reg,    zero_next;

    assign advance  = !out_valid_reg || out_ready;
    assign in_ready = advance;

    // ------------------------------------------------------------------
    // S1 combinational: field split and classification
    // ------------------------------------------------------------------
    always_comb begin
        s1_sign_next  = s0_opa_reg[31];
        s1_exp_next   = s0_opa_reg[30:23];
        s1_frac_next  = s0_opa_reg[22:0];
        s1_class_next = fp_classify(s0_opa_reg[30:23], s0_opa_reg[22:0]);
    end

    // ------------------------------------------------------------------
    // S2 combinational: alignment and out-of-range detection
    // ------------------------------------------------------------------
    logic [7:0]  shamt;
    logic [31:0] sh_int;
    logic        sh_guard;
    logic        sh_sticky;
    logic        exact_int_min;
    logic        overflow;

    // -2^31 is the single value with exponent 2^31 that still fits.
    assign exact_int_min = s1_sign_reg && (s1_exp_reg == EXP_INT_LIMIT) && (s1_frac_reg == 23'd0);
    assign overflow      = (s1_exp_reg >= EXP_INT_LIMIT) && !exact_int_min;

    // For exponents at or above the limit the shifter output is only used
    // in the exact -2^31 case, where a zero shift gives 0x80000000.
    assign shamt = (s1_class_reg == CLS_NORMAL && s1_exp_reg < EXP_INT_LIMIT)
                 ? (EXP_INT_LIMIT - s1_exp_reg) : 8'd0;

    fpu_align_shift u_align (
        .sig     ({1'b1, s1_frac_reg}),
        .shamt   (shamt),
        .int_mag (sh_int),
        .guard   (sh_guard),
        .sticky  (sh_sticky)
    );

    always_comb begin
        s2_nan_next    = 1'b0;
        s2_sat_next    = 1'b0;
        s2_int_next    = 32'd0;
        s2_guard_next  = 1'b0;
        s2_sticky_next = 1'b0;
        case (s1_class_reg)
            CLS_ZERO: begin
                s2_int_next = 32'd0;
            end
            CLS_DENORM: begin
                // Magnitude is far below 1/2: only the sticky bit survives,
                // which lets the directed modes round it away from zero.
                s2_sticky_next = 1'b1;
            end
            CLS_NORMAL: begin
                if (overflow) begin
                    s2_sat_next = 1'b1;
                end else begin
                    s2_int_next    = sh_int;
                    s2_guard_next  = sh_guard;
                    s2_sticky_next = sh_sticky;
                end
            end
            CLS_INF: begin
                s2_sat_next = 1'b1;
            end
            default: begin
                s2_nan_next = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // S3 combinational: round magnitude, negate, saturate
    // ------------------------------------------------------------------
    logic        round_up;
    logic        any_frac;
    logic [32:0] mag_ext;
    logic        mag_over;
    logic [31:0] signed_val;

    assign any_frac = s2_guard_reg || s2_sticky_reg;

    always_comb begin
        round_up = 1'b0;
        case (s2_mode_reg)
            RM_RNE:  round_up = s2_guard_reg && (s2_sticky_reg || s2_int_reg[0]);
            RM_RZ:   round_up = 1'b0;
            RM_RUP:  round_up = !s2_sign_reg && any_frac;
            RM_RDN:  round_up = s2_sign_reg && any_frac;
            default: round_up = 1'b0;
        endcase
    end

    assign mag_ext    = {1'b0, s2_int_reg} + {32'd0, round_up};
    // Negative results may reach 2^31; positive ones must stay below it.
    assign mag_over   = s2_sign_reg ? (mag_ext > 33'h0_8000_0000) : (mag_ext > 33'h0_7FFF_FFFF);
    assign signed_val = s2_sign_reg ? (~mag_ext[31:0] + 32'd1) : mag_ext[31:0];

    always_comb begin
        out_next     = signed_val;
        invalid_next = 1'b0;
        inexact_next = any_frac;
        zero_next    = (signed_val == 32'd0);
        if (s2_nan_reg) begin
            out_next     = INT_MAX;
            invalid_next = 1'b1;
            inexact_next = 1'b0;
            zero_next    = 1'b0;
        end else if (s2_sat_reg || mag_over) begin
            out_next     = s2_sign_reg ? INT_MIN : INT_MAX;
            invalid_next = 1'b1;
            inexact_next = 1'b0;
            zero_next    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_reg  <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_reg       <= 32'd0;
            invalid_reg   <= 1'b0;
            inexact_reg   <= 1'b0;
            zero_reg      <= 1'b0;
        end else if (advance) begin
            s0_valid_reg  <= in_valid;
            s1_valid_reg  <= s0_valid_reg;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            out_reg       <= out_next;
            invalid_reg   <= invalid_next;
            inexact_reg   <= inexact_next;
            zero_reg      <= zero_next;
        end
    end

    // Stage payloads need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (advance) begin
            s0_opa_reg    <= opa_in;
            s0_mode_reg   <= round_mode_t'(mode_in);
            s1_sign_reg   <= s1_sign_next;
            s1_exp_reg    <= s1_exp_next;
            s1_frac_reg   <= s1_frac_next;
            s1_class_reg  <= s1_class_next;
            s1_mode_reg   <= s0_mode_reg;
            s2_sign_reg   <= s1_sign_reg;
            s2_mode_reg   <= s1_mode_reg;
            s2_nan_reg    <= s2_nan_next;
            s2_sat_reg    <= s2_sat_next;
            s2_int_reg    <= s2_int_next;
            s2_guard_reg  <= s2_guard_next;
            s2_sticky_reg <= s2_sticky_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign invalid   = invalid_reg;
    assign inexact   = inexact_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_fpu_f2i.sv
// Self-checking bench for fpu_f2i. A value-level model (exact rational
// rounding of sign * mant * 2^(E-23), then int32 range check) produces the
// expected result of every accepted operand; one negedge monitor checks
// every consumed result, the handshake relation and stall holding.
module tb_fpu_f2i;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opa_in;
    logic [1:0]  mode_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        invalid;
    logic        inexact;
    logic        zero;

    int checks = 0;
    int errors = 0;
    int popped = 0;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  m;
        logic [31:0] o;
        logic [2:0]  f;   // {invalid, inexact, zero}
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    fpu_f2i dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opa_in    (opa_in),
        .mode_in   (mode_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .invalid   (invalid),
        .inexact   (inexact),
        .zero      (zero)
    );

    // Value-level reference: the float is the exact rational
    // mant * 2^(E-23); round it as a signed number, then range-check.
    function automatic void model(input logic [31:0] a, input logic [1:0] m,
                                  output logic [31:0] o, output logic [2:0] f);
        logic        s;
        int          e;
        int          sh;
        logic [22:0] fr;
        longint      mant, q, rem, half, t, r;
        logic        nz;
        int          cmp;
        s  = a[31];
        e  = int'(a[30:23]);
        fr = a[22:0];
        o  = 32'd0;
        f  = 3'b000;
        q  = 0;
        nz = 1'b0;
        cmp = -1;
        if (e == 255) begin
            o = (fr != 23'd0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
            f = 3'b100;
            return;
        end
        if (e == 0 && fr == 23'd0) begin
            o = 32'd0;
            f = 3'b001;
            return;
        end
        if (e == 0) begin
            q = 0; nz = 1'b1; cmp = -1;
        end else begin
            e    = e - 127;
            mant = longint'({1'b1, fr});
            if (e >= 31) begin
                if (s && e == 31 && fr == 23'd0) begin
                    o = 32'h8000_0000; f = 3'b000;
                end else begin
                    o = s ? 32'h8000_0000 : 32'h7FFF_FFFF; f = 3'b100;
                end
                return;
            end
            if (e >= 23) begin
                q = mant <<< (e - 23); nz = 1'b0;
            end else if (23 - e > 40) begin
                q = 0; nz = 1'b1; cmp = -1;
            end else begin
                sh   = 23 - e;
                q    = mant >>> sh;
                rem  = mant - (q <<< sh);
                half = longint'(1) <<< (sh - 1);
                nz   = (rem != 0);
                cmp  = (rem > half) ? 1 : ((rem == half) ? 0 : -1);
            end
        end
        t = s ? -q : q;
        case (m)
            2'b00: begin
                if (!nz || cmp < 0) r = t;
                else if (cmp > 0 || q[0]) r = s ? t - 1 : t + 1;
                else r = t;
            end
            2'b01:   r = t;
            2'b10:   r = (nz && !s) ? t + 1 : t;
            default: r = (nz && s) ? t - 1 : t;
        endcase
        if (r > 64'sd2147483647 || r < -64'sd2147483648) begin
            o = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            f = 3'b100;
            return;
        end
        o = r[31:0];
        f = {1'b0, nz, (o == 32'd0)};
    endfunction

    // Monitor: runs on the falling edge, where every signal is stable.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_out;
    logic [2:0]  prev_f;

    always @(negedge clk) begin
        vec_t e;
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready_relation t=%0t got %b want %b", $time, in_ready, !out_valid || out_ready);
            end
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out !== prev_out || {invalid, inexact, zero} !== prev_f) begin
                    errors++;
                    $display("FAIL stall_hold t=%0t got v=%b %h %b want v=1 %h %b", $time, out_valid, out, {invalid, inexact, zero}, prev_out, prev_f);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                popped++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result t=%0t got %h flags %b want no result", $time, out, {invalid, inexact, zero});
                end else begin
                    e = exp_q.pop_front();
                    if (out !== e.o || {invalid, inexact, zero} !== e.f) begin
                        errors++;
                        $display("FAIL result a=%h m=%0d got %h flags %b want %h flags %b", e.a, e.m, out, {invalid, inexact, zero}, e.o, e.f);
                    end else begin
                        $display("txn a=%h m=%0d out=%h flags(inv,inx,zero)=%b", e.a, e.m, out, {invalid, inexact, zero});
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.a = opa_in;
                e.m = mode_in;
                model(opa_in, mode_in, e.o, e.f);
                exp_q.push_back(e);
            end
            hold_prev = out_valid && !out_ready;
            prev_out  = out;
            prev_f    = {invalid, inexact, zero};
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [1:0] m, input logic [31:0] o, input logic [2:0] f);
        vec_t v;
        v.a = a; v.m = m; v.o = o; v.f = f;
        vecs.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [1:0] m);
        logic acc;
        int   n;
        opa_in   = a;
        mode_in  = m;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout a=%h got no accept want accept", a);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic latency_test(input logic [31:0] a);
        logic want;
        opa_in   = a;
        mode_in  = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            want = (i == 3);
            check($sformatf("latency_edge_k+%0d", i), {31'd0, out_valid}, {31'd0, want});
        end
        drain();
    endtask

    initial begin
        logic [31:0] mo;
        logic [2:0]  mf;
        int          base;

        rst       = 1'b1;
        in_valid  = 1'b0;
        opa_in    = 32'd0;
        mode_in   = 2'b00;
        out_ready = 1'b1;

        // Hand-computed expectations: {invalid, inexact, zero}
        add_vec(32'h3F80_0000, 2'b00, 32'h0000_0001, 3'b000);
        add_vec(32'h4020_0000, 2'b00, 32'h0000_0002, 3'b010);
        add_vec(32'h4020_0000, 2'b10, 32'h0000_0003, 3'b010);
        add_vec(32'h4020_0000, 2'b01, 32'h0000_0002, 3'b010);
        add_vec(32'hC020_0000, 2'b11, 32'hFFFF_FFFD, 3'b010);
        add_vec(32'hC020_0000, 2'b01, 32'hFFFF_FFFE, 3'b010);
        add_vec(32'hC020_0000, 2'b10, 32'hFFFF_FFFE, 3'b010);
        add_vec(32'h4F00_0000, 2'b00, 32'h7FFF_FFFF, 3'b100);
        add_vec(32'hCF00_0000, 2'b00, 32'h8000_0000, 3'b000);
        add_vec(32'hCF00_0001, 2'b01, 32'h8000_0000, 3'b100);
        add_vec(32'h7FC0_0000, 2'b00, 32'h7FFF_FFFF, 3'b100);
        add_vec(32'hFF80_0001, 2'b11, 32'h7FFF_FFFF, 3'b100);
        add_vec(32'h7F80_0000, 2'b00, 32'h7FFF_FFFF, 3'b100);
        add_vec(32'hFF80_0000, 2'b00, 32'h8000_0000, 3'b100);
        add_vec(32'h0000_0000, 2'b00, 32'h0000_0000, 3'b001);
        add_vec(32'h8000_0000, 2'b11, 32'h0000_0000, 3'b001);
        add_vec(32'h8000_0001, 2'b11, 32'hFFFF_FFFF, 3'b010);
        add_vec(32'h8000_0001, 2'b00, 32'h0000_0000, 3'b011);
        add_vec(32'h0000_0001, 2'b10, 32'h0000_0001, 3'b010);
        add_vec(32'h0000_0001, 2'b11, 32'h0000_0000, 3'b011);
        add_vec(32'h3F00_0000, 2'b00, 32'h0000_0000, 3'b011);
        add_vec(32'h3FC0_0000, 2'b00, 32'h0000_0002, 3'b010);
        add_vec(32'h3F20_0000, 2'b00, 32'h0000_0001, 3'b010);
        add_vec(32'hBF40_0000, 2'b00, 32'hFFFF_FFFF, 3'b010);
        add_vec(32'hBF40_0000, 2'b01, 32'h0000_0000, 3'b011);
        add_vec(32'h4EFF_FFFF, 2'b00, 32'h7FFF_FF80, 3'b000);
        add_vec(32'h4B80_0001, 2'b00, 32'h0100_0002, 3'b000);
        add_vec(32'hC0A0_0000, 2'b00, 32'hFFFF_FFFB, 3'b000);

        // Pin the model against the hand-computed table.
        foreach (vecs[i]) begin
            model(vecs[i].a, vecs[i].m, mo, mf);
            check($sformatf("model_pin_%0d_out", i), mo, vecs[i].o);
            check($sformatf("model_pin_%0d_flags", i), {29'd0, mf}, {29'd0, vecs[i].f});
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out", out, 32'd0);
        check("reset_flags", {29'd0, invalid, inexact, zero}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency of a lone operand
        latency_test(32'h40A0_0000);

        // Directed vectors back to back, out_ready high
        foreach (vecs[i]) send(vecs[i].a, vecs[i].m);
        drain();

        // Backpressure: 1.0..6.0 with out_ready low for 5 cycles mid-stream
        base = popped;
        fork
            begin
                send(32'h3F80_0000, 2'b00);
                send(32'h4000_0000, 2'b00);
                send(32'h4040_0000, 2'b00);
                send(32'h4080_0000, 2'b00);
                send(32'h40A0_0000, 2'b00);
                send(32'h40C0_0000, 2'b00);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("backpressure_count", popped - base, 32'd6);

        // Same table under a pseudo-random out_ready pattern
        fork
            begin
                foreach (vecs[i]) send(vecs[i].a, vecs[i].m);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset mid-stream with three operands in flight; an operand
        // presented during reset must be ignored.
        base = popped;
        send(32'h4000_0000, 2'b00);
        send(32'h4040_0000, 2'b00);
        send(32'h4080_0000, 2'b00);
        rst      = 1'b1;
        in_valid = 1'b1;
        opa_in   = 32'h3F80_0000;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_out", out, 32'd0);
        check("midreset_flags", {29'd0, invalid, inexact, zero}, 32'd0);
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("midreset_no_stale", popped - base, 32'd0);
        latency_test(32'h40C0_0000);
        check("post_reset_count", popped - base, 32'd1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_f2i.md
FPU_F2I -- requirements
Module: fpu_f2i

Interface
REQ-001 Ports: clk  input  1  rising-edge clock.
REQ-002 Ports: rst  input  1  reset, synchronous, active-high.
REQ-003 Ports: in_valid  input  1  operand present.
REQ-004 Ports: in_ready  output  1  operand accepted when in_valid && in_ready at a clock edge.
REQ-005 Ports: opa_in  input  32  IEEE 754 single-precision operand.
REQ-006 Ports: mode_in  input  2  rounding mode (00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf), sampled with opa_in.
REQ-007 Ports: out_valid  output  1  result present.
REQ-008 Ports: out_ready  input  1  result consumed when out_valid && out_ready at a clock edge.
REQ-009 Ports: out  output  32  signed two's-complement integer result.
REQ-010 Ports: invalid, inexact, zero  output  1 each  flags qualified by out_valid.

Function
REQ-011 The block SHALL convert opa_in to a signed 32-bit integer using mode_in.
REQ-012 Pipeline: S1 unpack/classify, S2 align (right shift of {1,frac} into 32 integer bits plus guard and sticky), S3 round, negate, saturate, register outputs.
REQ-013 Latency: an operand accepted at edge k SHALL appear with out_valid=1 after edge k+3 when out_ready stays high.
REQ-014 Throughput: one operand per cycle with out_ready high.
REQ-015 Stall: global advance = !out_valid || out_ready; in_ready SHALL equal advance; when advance=0 every stage SHALL hold.
REQ-016 Results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-017 Bubbles (in_valid=0 on an advancing cycle) SHALL propagate as invalid stage entries.
REQ-018 Zero (exp=0, frac=0, either sign): out=0, zero=1, inexact=0, invalid=0.
REQ-019 Denormal (exp=0, frac!=0): inexact=1, invalid=0.
  - RNE/RZ: out=0, zero=1.
  - RUP: out=+1 if positive, else 0.
  - RDN: out=-1 if negative, else 0.
REQ-020 NaN (exp=255, frac!=0): out=0x7FFFFFFF, invalid=1, inexact=0.
REQ-021 Infinities: +inf gives out=0x7FFFFFFF, -inf gives out=0x80000000; invalid=1 in both cases.
REQ-022 Range check on unbiased exponent E=exp-127:
  - E>=31 with value other than exactly -2^31 (0xCF000000): saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative), invalid=1.
  - 0xCF000000: out=0x80000000, no flags.
REQ-023 Normal numbers with E<0: result SHALL be rounded from guard and sticky per the mode; RNE ties to even, so 0.5 gives 0 and 1.5 gives 2.
REQ-024 Rounding SHALL apply to the magnitude according to the sign: RUP rounds positive magnitudes up, RDN rounds negative magnitudes up, then two's-complement negation when sign=1.
REQ-025 inexact=1 iff guard or sticky is nonzero, for finite in-range inputs.
REQ-026 zero=1 iff out==0 and the input is not NaN.
REQ-027 Flags SHALL be mutually consistent; invalid=1 forces inexact=0.

Reset
REQ-028 On rst=1 at a clock edge, all stage valid bits and out_valid SHALL be 0, and out, invalid, inexact, zero SHALL be 0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset.
REQ-030 rst mid-stream SHALL discard all in-flight operands; no result for them SHALL ever appear.
REQ-031 rst SHALL take priority over out_ready and in_valid in the same cycle.

Structure
REQ-032 Package fpu_pkg SHALL hold:
  - rounding-mode encodings (RNE, RZ, RUP, RDN);
  - constants EXP_BIAS=127, EXP_MAX=255, INT_MAX=0x7FFFFFFF, INT_MIN=0x80000000;
  - operand-class enumeration (zero, denormal, normal, inf, nan).
REQ-033 The package SHALL be shared with the existing fpu adder.
REQ-034 One sub-module, fpu_align_shift: combinational right shifter, 24-bit significand plus shift amount in, 32-bit integer plus guard plus sticky out; instantiated in S2.

Verification
REQ-035 0x3F800000, RNE -> out=1, no flags; 0x40200000 (2.5): RNE -> 2 inexact=1; RUP -> 3 inexact=1.
REQ-036 0xC0200000 (-2.5): RDN -> 0xFFFFFFFD; RZ -> 0xFFFFFFFE; both inexact=1.
REQ-037 Boundary: 0x4F000000 -> 0x7FFFFFFF invalid=1; 0xCF000000 -> 0x80000000 no flags; 0x7FC00000 -> 0x7FFFFFFF invalid=1; 0x00000000 -> 0 zero=1.
REQ-038 Denormal 0x80000001: RDN -> 0xFFFFFFFF inexact=1; RNE -> 0 zero=1 inexact=1.
REQ-039 Backpressure: 6 back-to-back operands 1.0..6.0 with out_ready low for 5 cycles mid-stream -> outputs 1..6 in order, none lost or duplicated, in_ready low while stalled.
REQ-040 Reset mid-stream: rst pulsed one cycle with 3 operands in flight -> out_valid=0 next cycle and no stale result ever emitted; the next operand after reset converts with 3-cycle latency.
